// File: rtl/rsa_mont_exp.sv
`default_nettype none
// ============================================================================
// rsa_mont_exp : a^d mod n by LSB-first square-and-multiply, driving an
//                external Montgomery multiplier.            Rev 1.0
// ============================================================================
module rsa_mont_exp #(
  parameter int W = 256
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_d,
  input  logic [W-1:0] i_n,
  output logic [W-1:0] o_a_pow_d,
  output logic         o_finished,
  output logic         o_MA_start,
  output logic [W-1:0] o_MA_n,
  output logic [W-1:0] o_MA_a,
  output logic [W-1:0] o_MA_b,
  input  logic [W-1:0] i_MA,
  input  logic         i_MA_end
);

  localparam int            IW       = $clog2(W);
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  typedef enum logic [2:0] {
    IDLE, PREP, CHK, MUL_M, WAIT_M, MUL_T, WAIT_T, DONE
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [W-1:0]  r_d;
  logic [W-1:0]  r_n;
  logic [W-1:0]  r_m;
  logic [W-1:0]  r_t;
  logic [W-1:0]  r_result;
  logic [IW-1:0] r_idx;
  logic [W:0]    w_t2;
  logic [W-1:0]  w_t_dbl;
  logic          w_last;

  assign w_last = (r_idx == LAST_IDX);

  // Doubling step of the conversion into the Montgomery domain; t < n keeps
  // the reduced value inside W bits.
  always_comb begin
    w_t2    = {r_t, 1'b0};
    w_t_dbl = w_t2[W-1:0];
    if (w_t2 >= {1'b0, r_n}) begin
      w_t_dbl = w_t2[W-1:0] - r_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next_state = PREP;
      PREP:    if (w_last) w_next_state = CHK;
      CHK:     w_next_state = r_d[r_idx] ? MUL_M : MUL_T;
      MUL_M:   w_next_state = WAIT_M;
      WAIT_M:  if (i_MA_end) w_next_state = MUL_T;
      MUL_T:   w_next_state = WAIT_T;
      WAIT_T:  if (i_MA_end) w_next_state = w_last ? DONE : CHK;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Operands follow the state, so they stay put for the whole MUL/WAIT pair.
  always_comb begin
    o_MA_start = 1'b0;
    o_MA_a     = '0;
    o_MA_b     = '0;
    case (r_state)
      MUL_M, WAIT_M: begin
        o_MA_a     = r_m;
        o_MA_b     = r_t;
        o_MA_start = (r_state == MUL_M);
      end
      MUL_T, WAIT_T: begin
        o_MA_a     = r_t;
        o_MA_b     = r_t;
        o_MA_start = (r_state == MUL_T);
      end
      default: ;
    endcase
  end

  assign o_MA_n     = r_n;
  assign o_finished = (r_state == DONE);
  assign o_a_pow_d  = r_result;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_d      <= '0;
      r_n      <= '0;
      r_m      <= '0;
      r_t      <= '0;
      r_result <= '0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_d   <= i_d;
            r_n   <= i_n;
            r_m   <= {{(W-1){1'b0}}, 1'b1};
            r_t   <= i_a;
            r_idx <= '0;
          end
        end
        PREP: begin
          r_t   <= w_t_dbl;
          r_idx <= w_last ? '0 : r_idx + IW'(1);
        end
        WAIT_M: begin
          if (i_MA_end) r_m <= i_MA;
        end
        WAIT_T: begin
          if (i_MA_end) begin
            r_t <= i_MA;
            if (w_last) begin
              r_result <= r_m;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rsa_mont_exp.sv
`default_nettype none
// tb_rsa_mont_exp : Montgomery responder plus plain modexp reference model.
module tb_rsa_mont_exp;

  localparam int W = 256;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] d_in = '0;
  logic [W-1:0] n_in = '0;
  logic         resp_end = 1'b0;
  logic [W-1:0] resp_val = '0;
  logic         inj_end = 1'b0;
  logic [W-1:0] inj_val = '0;

  wire  [W-1:0] a_pow_d;
  wire          finished;
  wire          ma_start;
  wire  [W-1:0] ma_n;
  wire  [W-1:0] ma_a;
  wire  [W-1:0] ma_b;
  wire  [W-1:0] ma_res;
  wire          ma_end;

  assign ma_end = resp_end | inj_end;
  assign ma_res = resp_end ? resp_val : inj_val;

  rsa_mont_exp #(.W(W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_a        (a_in),
    .i_d        (d_in),
    .i_n        (n_in),
    .o_a_pow_d  (a_pow_d),
    .o_finished (finished),
    .o_MA_start (ma_start),
    .o_MA_n     (ma_n),
    .o_MA_a     (ma_a),
    .o_MA_b     (ma_b),
    .i_MA       (ma_res),
    .i_MA_end   (ma_end)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_starts = 0;
  int n_fin = 0;
  int stab_viol = 0;
  int spacing_viol = 0;
  int resp_k = 5;
  int cnt = 0;
  bit abort = 1'b0;
  bit prev_start = 1'b0;
  logic [W-1:0] la = '0;
  logic [W-1:0] lb = '0;
  logic [W-1:0] ln = '0;
  int s_cyc = 0;
  int s_starts = 0;
  int s_fin = 0;
  int s_stab = 0;
  int s_space = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // x*y*2^-W mod n by bitwise REDC
  function automatic logic [W-1:0] mont(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic [W-1:0] n);
    logic [2*W+1:0] acc;
    acc = (2*W+2)'(x) * (2*W+2)'(y);
    for (int i = 0; i < W; i++) begin
      if (acc[0]) acc = acc + (2*W+2)'(n);
      acc = acc >> 1;
    end
    if (acc >= (2*W+2)'(n)) acc = acc - (2*W+2)'(n);
    return acc[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] a, input logic [W-1:0] d,
                                           input logic [W-1:0] n);
    logic [2*W-1:0] r, b, m;
    m = (2*W)'(n);
    r = (2*W)'(1);
    b = (2*W)'(a) % m;
    for (int i = 0; i < W; i++) begin
      if (d[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / 32; i++) r = {r[W-33:0], 32'($urandom())};
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (finished) n_fin++;
  end

  // Multiplier responder: end pulse K cycles after the start pulse.
  always @(negedge clk) begin
    resp_end = 1'b0;
    if (rst) abort = 1'b1;
    if (cnt > 0) begin
      if (!abort && (ma_a !== la || ma_b !== lb || ma_n !== ln)) stab_viol++;
      cnt--;
      if (cnt == 0) begin
        resp_end = 1'b1;
        resp_val = mont(la, lb, ln);
        abort    = 1'b0;
      end
    end
    if (ma_start) begin
      n_starts++;
      if (cnt > 0 || prev_start) spacing_viol++;
      la  = ma_a;
      lb  = ma_b;
      ln  = ma_n;
      cnt = (resp_k == 0) ? int'($urandom_range(20, 1)) : resp_k;
    end
    prev_start = ma_start;
  end

  // Called at a negedge while the DUT is idle; returns one negedge later.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] d, input logic [W-1:0] n);
    a_in     = a;
    d_in     = d;
    n_in     = n;
    start    = 1'b1;
    s_cyc    = cyc;
    s_starts = n_starts;
    s_fin    = n_fin;
    s_stab   = stab_viol;
    s_space  = spacing_viol;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_checks(input string tag, input logic [W-1:0] exp,
                               input logic [W-1:0] d, input int k);
    int fc;
    int mults;
    fc = -1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (finished) begin
        fc = cyc;
        break;
      end
    end
    check({tag, "_done_seen"}, W'(finished), W'(1));
    mults = W + $countones(d);
    check({tag, "_result"}, a_pow_d, exp);
    check({tag, "_mults"}, W'(n_starts - s_starts), W'(mults));
    if (k > 0) check({tag, "_cycles"}, W'(fc - s_cyc), W'(1 + 2 * W + mults * (1 + k)));
    check({tag, "_stable"}, W'(stab_viol - s_stab), '0);
    check({tag, "_spacing"}, W'(spacing_viol - s_space), '0);
    @(negedge clk);
    check({tag, "_finish_once"}, W'(n_fin - s_fin), W'(1));
    check({tag, "_hold"}, a_pow_d, exp);
  endtask

  initial begin
    logic [W-1:0] ra, rd, rn;
    int base_starts;
    int base_fin;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_finished", W'(finished), '0);
    check("rst_ma_start", W'(ma_start), '0);
    check("rst_result", a_pow_d, '0);
    check("rst_ma_a", ma_a, '0);
    check("rst_ma_b", ma_b, '0);
    check("rst_ma_n", ma_n, '0);

    resp_k = 5;
    @(negedge clk);
    start_op(W'(2), W'(7), W'(143));
    finish_checks("pow2_7", W'(128), W'(7), 5);

    start_op(W'(5), W'(0), W'(143));
    finish_checks("d_zero", W'(1), W'(0), 5);

    // d=1 with a stray multiplier end pulse injected during the first CHK
    start_op(W'(5), W'(1), W'(143));
    repeat (256) @(negedge clk);
    inj_val = rand_w();
    inj_end = 1'b1;
    @(negedge clk);
    inj_end = 1'b0;
    finish_checks("d_one", W'(5), W'(1), 5);

    start_op(W'(65), W'(17), W'(3233));
    finish_checks("rsa_enc", W'(2790), W'(17), 5);
    start_op(W'(2790), W'(2753), W'(3233));
    finish_checks("rsa_dec", W'(65), W'(2753), 5);

    // Starts during PREP and during the first WAIT_T must be ignored
    start_op(W'(2), W'(6), W'(143));
    repeat (100) @(negedge clk);
    a_in  = W'(7);
    d_in  = W'(9);
    n_in  = W'(221);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (ma_start) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    a_in  = W'(11);
    d_in  = W'(3);
    n_in  = W'(187);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_checks("ignore_start", W'(64), W'(6), 5);

    // Reset while waiting on the first MUL_M result
    start_op(W'(2), W'(7), W'(143));
    for (int i = 0; i < 2000; i++) begin
      if (ma_start) break;
      @(negedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ma_start", W'(ma_start), '0);
    check("abort_finished", W'(finished), '0);
    check("abort_ma_a", ma_a, '0);
    @(negedge clk);
    rst = 1'b0;
    base_starts = n_starts;
    base_fin    = n_fin;
    repeat (20) @(negedge clk);
    check("abort_idle_starts", W'(n_starts - base_starts), '0);
    check("abort_idle_fin", W'(n_fin - base_fin), '0);
    start_op(W'(2), W'(7), W'(143));
    finish_checks("after_abort", W'(128), W'(7), 5);

    // Random operands with per-multiply random responder latency
    resp_k = 0;
    for (int r = 0; r < 2; r++) begin
      rn = rand_w();
      rn[0] = 1'b1;
      ra = rand_w() % rn;
      rd = rand_w();
      start_op(ra, rd, rn);
      finish_checks("random", ref_pow(ra, rd, rn), rd, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
